md_update_arbiter: RTL and testbench

- Shares the single order-book update port between N_REQ decoded-message sources (parallel feed handlers/parsers), all already in clk_sys.
- Round-robin arbitration, per-requester enable mask, one registered output stage with valid/ready handshake.
- Sits between the parser-side synchronisers and the order book; drives its symbol/price/quantity/side/update_valid inputs.

---
 rtl/md_pkg.sv | 20 ++
 rtl/rr_pick.sv | 37 +++
 rtl/md_update_arbiter.sv | 142 ++++++++++++++
 tb/tb_md_update_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared constants and types for the market-data update path: payload widths,
// side codes and the output-stage state encoding.
package md_pkg;

  localparam int SYM_W  = 64;
  localparam int PX_W   = 32;
  localparam int QTY_W  = 32;
  localparam int SIDE_W = 8;

  typedef enum logic [7:0] {
    SIDE_BID = 8'h42,
    SIDE_ASK = 8'h53
  } side_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after rr_ptr, with an
// optional strict-priority requester 0 that is never part of the rotation.
module rr_pick #(
  parameter int N     = 4,
  parameter bit PRIO0 = 1'b0,
  localparam int IW   = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (PRIO0 && eligible[0]) begin
      grant_oh[0] = 1'b1;
      grant_any   = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = IW'((int'(rr_ptr) + k) % N);
        if (!grant_any && eligible[cand] && !(PRIO0 && cand == '0)) begin
          grant_oh[cand] = 1'b1;
          grant_idx      = cand;
          grant_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/md_update_arbiter.sv
// Round-robin arbiter sharing the order-book update port between N_REQ parsers,
// with one registered output stage. Define MD_ARB_PRIO0_EN for strict priority on requester 0.
module md_update_arbiter
  import md_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int SYM_W  = md_pkg::SYM_W,
  parameter int PX_W   = md_pkg::PX_W,
  parameter int QTY_W  = md_pkg::QTY_W,
  parameter int SIDE_W = md_pkg::SIDE_W,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                      clk_sys,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          cfg_req_en,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*SYM_W-1:0]    req_symbol,
  input  logic [N_REQ*PX_W-1:0]     req_price,
  input  logic [N_REQ*QTY_W-1:0]    req_qty,
  input  logic [N_REQ*SIDE_W-1:0]   req_side,
  output logic [SYM_W-1:0]          upd_symbol,
  output logic [PX_W-1:0]           upd_price,
  output logic [QTY_W-1:0]          upd_qty,
  output logic [SIDE_W-1:0]         upd_side,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [IW-1:0]             upd_src,
  output logic [31:0]               grant_count,
  output logic [31:0]               stall_count
);

`ifdef MD_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  // Handshake: a requester's message moves when req_valid[i] & req_ready[i];
  // the order book takes upd_* when upd_valid & upd_ready. req_ready is combinational.
  out_state_e        state_q, state_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [QTY_W-1:0]  qty_q, qty_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [IW-1:0]     src_q, src_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]       grant_cnt_q, grant_cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [SYM_W-1:0]  sym_arr  [N_REQ];
  logic [PX_W-1:0]   px_arr   [N_REQ];
  logic [QTY_W-1:0]  qty_arr  [N_REQ];
  logic [SIDE_W-1:0] side_arr [N_REQ];

  logic [N_REQ-1:0]  grant_oh;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic              out_free;
  logic              do_grant;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      sym_arr[i]  = req_symbol[i*SYM_W +: SYM_W];
      px_arr[i]   = req_price[i*PX_W +: PX_W];
      qty_arr[i]  = req_qty[i*QTY_W +: QTY_W];
      side_arr[i] = req_side[i*SIDE_W +: SIDE_W];
    end
  end

  rr_pick #(.N(N_REQ), .PRIO0(PRIO0)) u_pick (
    .eligible  (req_valid & cfg_req_en),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Gating with rstn keeps req_ready low while the stage is held in reset.
  assign out_free  = (state_q == OUT_EMPTY) || upd_ready;
  assign do_grant  = out_free && grant_any && rstn;
  assign req_ready = do_grant ? grant_oh : '0;

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    px_d        = px_q;
    qty_d       = qty_q;
    side_d      = side_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (do_grant) begin
      state_d     = OUT_FULL;
      sym_d       = sym_arr[grant_idx];
      px_d        = px_arr[grant_idx];
      qty_d       = qty_arr[grant_idx];
      side_d      = side_arr[grant_idx];
      src_d       = grant_idx;
      grant_cnt_d = grant_cnt_q + 32'd1;
      if (!(PRIO0 && grant_idx == '0)) rr_ptr_d = grant_idx;
    end else if (state_q == OUT_FULL && upd_ready) begin
      state_d = OUT_EMPTY;
    end
    if (state_q == OUT_FULL && !upd_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      state_q     <= OUT_EMPTY;
      sym_q       <= '0;
      px_q        <= '0;
      qty_q       <= '0;
      side_q      <= '0;
      src_q       <= '0;
      rr_ptr_q    <= IW'(N_REQ - 1);
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      px_q        <= px_d;
      qty_q       <= qty_d;
      side_q      <= side_d;
      src_q       <= src_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign upd_valid   = (state_q == OUT_FULL);
  assign upd_symbol  = sym_q;
  assign upd_price   = px_q;
  assign upd_qty     = qty_q;
  assign upd_side    = side_q;
  assign upd_src     = src_q;
  assign grant_count = grant_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_md_update_arbiter.sv
// Bench for md_update_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_md_update_arbiter;
  import md_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SW = IW + PX_W;

  logic              clk_sys = 1'b0;
  logic              rstn;
  logic [N-1:0]      cfg_req_en, req_valid, req_ready;
  logic [N*SYM_W-1:0]  req_symbol;
  logic [N*PX_W-1:0]   req_price;
  logic [N*QTY_W-1:0]  req_qty;
  logic [N*SIDE_W-1:0] req_side;
  logic [SYM_W-1:0]  upd_symbol;
  logic [PX_W-1:0]   upd_price;
  logic [QTY_W-1:0]  upd_qty;
  logic [SIDE_W-1:0] upd_side;
  logic              upd_valid, upd_ready;
  logic [IW-1:0]     upd_src;
  logic [31:0]       grant_count, stall_count;

  md_update_arbiter dut (
    .clk_sys(clk_sys), .rstn(rstn), .cfg_req_en(cfg_req_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_symbol(req_symbol), .req_price(req_price), .req_qty(req_qty), .req_side(req_side),
    .upd_symbol(upd_symbol), .upd_price(upd_price), .upd_qty(upd_qty), .upd_side(upd_side),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_src(upd_src),
    .grant_count(grant_count), .stall_count(stall_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    upd_ready = 1'b0;
    cfg_req_en = '1;
    repeat (2) @(posedge clk_sys);
    #1 rstn = 1'b1;
  endtask

  // ---------------- driver ----------------
  logic [SYM_W-1:0]  p_sym  [N];
  logic [PX_W-1:0]   p_px   [N];
  logic [QTY_W-1:0]  p_qty  [N];
  logic [SIDE_W-1:0] p_side [N];

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      req_symbol[i*SYM_W +: SYM_W]   = p_sym[i];
      req_price[i*PX_W +: PX_W]      = p_px[i];
      req_qty[i*QTY_W +: QTY_W]      = p_qty[i];
      req_side[i*SIDE_W +: SIDE_W]   = p_side[i];
    end
  endtask

  task automatic fixed_payload();
    for (int i = 0; i < N; i++) begin
      p_sym[i]  = 64'hA000 + 64'(i);
      p_px[i]   = 32'd100 + 32'(i);
      p_qty[i]  = 32'd10 + 32'(i);
      p_side[i] = (i % 2 == 0) ? SIDE_BID : SIDE_ASK;
    end
    drive_payload();
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner = eligible requester closest after rr (distance measured mod N).
  function automatic int model_pick(input logic [N-1:0] elig, input int rr);
    int best, bestd, d;
    best = -1;
    bestd = N;
`ifdef MD_ARB_PRIO0_EN
    if (elig[0]) return 0;
    elig[0] = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        d = (i - rr - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  rv;
    logic [N-1:0]  en;
    logic          ur;
    logic [N-1:0]  rdy;
    logic          vld;
    logic [IW-1:0] src;
  } vec_t;

  vec_t tbl [15];

  int   exp_gc, exp_sc;
  logic exp_full;
  logic [PX_W-1:0] held_px;

  logic           m_valid;
  logic [IW-1:0]  m_src;
  logic [SYM_W-1:0] m_sym;
  logic [PX_W-1:0]  m_px;
  logic [QTY_W-1:0] m_qty;
  logic [SIDE_W-1:0] m_side;
  int             m_rr, m_gc, m_sc, g;
  logic [N-1:0]   pend, m_rdy;
  logic [SW-1:0]  front;

  initial begin
    tbl[0]  = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[7]  = '{4'b1111, 4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[11] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[12] = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[13] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[14] = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};

    fixed_payload();
    rstn = 1'b0;
    req_valid = '0;
    cfg_req_en = '1;
    upd_ready = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_upd_valid", 64'(upd_valid), 64'd0);
    check("reset_upd_price", 64'(upd_price), 64'd0);
    check("reset_upd_src", 64'(upd_src), 64'd0);
    check("reset_grant_count", 64'(grant_count), 64'd0);
    check("reset_stall_count", 64'(stall_count), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    rstn = 1'b1;

`ifndef MD_ARB_PRIO0_EN
    // Directed table: one row per clock from the reset state.
    exp_gc = 0;
    exp_sc = 0;
    exp_full = 1'b0;
    for (int r = 0; r < 15; r++) begin
      req_valid = tbl[r].rv;
      cfg_req_en = tbl[r].en;
      upd_ready = tbl[r].ur;
      #1;
      check($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      if (tbl[r].rdy != '0) exp_gc++;
      if (exp_full && !tbl[r].ur) exp_sc++;
      exp_full = tbl[r].vld;
      @(posedge clk_sys);
      #1;
      check($sformatf("tbl%0d_upd_valid", r), 64'(upd_valid), 64'(tbl[r].vld));
      if (tbl[r].vld) begin
        check($sformatf("tbl%0d_upd_src", r), 64'(upd_src), 64'(tbl[r].src));
        check($sformatf("tbl%0d_upd_price", r), 64'(upd_price), 64'd100 + 64'(tbl[r].src));
      end
      check($sformatf("tbl%0d_grant_count", r), 64'(grant_count), 64'(exp_gc));
      check($sformatf("tbl%0d_stall_count", r), 64'(stall_count), 64'(exp_sc));
    end

    // Five stalled cycles on a FULL entry from requester 0, then release.
    req_valid = 4'b1111;
    cfg_req_en = 4'b1111;
    upd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk_sys);
      #1;
      check("stall_upd_price", 64'(upd_price), 64'd100);
      check("stall_upd_src", 64'(upd_src), 64'd0);
    end
    check("stall_count_plus5", 64'(stall_count), 64'(exp_sc + 5));
    upd_ready = 1'b1;
    #1;
    check("stall_release_req_ready", 64'(req_ready), 64'b0010);
    @(posedge clk_sys);
    #1;
    check("stall_release_src", 64'(upd_src), 64'd1);

    // Async reset in the middle of a stall.
    upd_ready = 1'b0;
    @(posedge clk_sys);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_upd_valid", 64'(upd_valid), 64'd0);
    check("midrst_upd_price", 64'(upd_price), 64'd0);
    check("midrst_grant_count", 64'(grant_count), 64'd0);
    check("midrst_stall_count", 64'(stall_count), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk_sys);
    #1;
    rstn = 1'b1;
    upd_ready = 1'b1;
    #1;
    check("postrst_req_ready", 64'(req_ready), 64'b0001);
    @(posedge clk_sys);
    #1;
    check("postrst_upd_src", 64'(upd_src), 64'd0);
    check("postrst_grant_count", 64'(grant_count), 64'd1);
`else
    // Strict priority: requester 0 beats 2 until it drops.
    upd_ready = 1'b1;
    cfg_req_en = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c < 3) ? 4'b0101 : 4'b0100;
      #1;
      check("prio_req_ready", 64'(req_ready), (c < 3) ? 64'b0001 : 64'b0100);
      @(posedge clk_sys);
      #1;
      check("prio_upd_src", 64'(upd_src), (c < 3) ? 64'd0 : 64'd2);
    end
`endif

    // Randomized run against the reference model.
    do_reset();
    m_valid = 1'b0; m_src = '0; m_sym = '0; m_px = '0; m_qty = '0; m_side = '0;
    m_rr = N - 1; m_gc = 0; m_sc = 0;
    pend = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]   = 1'b1;
          p_sym[i]  = {$urandom, $urandom};
          p_px[i]   = $urandom;
          p_qty[i]  = $urandom;
          p_side[i] = $urandom_range(0, 1) ? SIDE_BID : SIDE_ASK;
        end
      end
      drive_payload();
      req_valid = pend;
      if ($urandom_range(0, 31) == 0) cfg_req_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) cfg_req_en = 4'b1111;
      upd_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_upd_valid", 64'(upd_valid), 64'(m_valid));
      if (m_valid) begin
        check("rnd_upd_src", 64'(upd_src), 64'(m_src));
        check("rnd_upd_symbol", upd_symbol, m_sym);
        check("rnd_upd_price", 64'(upd_price), 64'(m_px));
        check("rnd_upd_qty", 64'(upd_qty), 64'(m_qty));
        check("rnd_upd_side", 64'(upd_side), 64'(m_side));
      end
      check("rnd_grant_count", 64'(grant_count), 64'(m_gc));
      check("rnd_stall_count", 64'(stall_count), 64'(m_sc));
      if (upd_valid && upd_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_sb_underflow", 64'd1, 64'd0);
        end else begin
          front = exp_q.pop_front();
          check("rnd_sb_delivery", 64'({upd_src, upd_price}), 64'(front));
        end
      end
      if (m_valid && !upd_ready) m_sc++;
      g = (!m_valid || upd_ready) ? model_pick(req_valid & cfg_req_en, m_rr) : -1;
      m_rdy = '0;
      if (g >= 0) m_rdy[g] = 1'b1;
      check("rnd_req_ready", 64'(req_ready), 64'(m_rdy));
      if (g >= 0) begin
        m_valid = 1'b1;
        m_src   = IW'(g);
        m_sym   = p_sym[g];
        m_px    = p_px[g];
        m_qty   = p_qty[g];
        m_side  = p_side[g];
        m_gc++;
`ifdef MD_ARB_PRIO0_EN
        if (g != 0) m_rr = g;
`else
        m_rr = g;
`endif
        exp_q.push_back({IW'(g), p_px[g]});
        pend[g] = 1'b0;
      end else if (m_valid && upd_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk_sys);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
